// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg : shared types, opcode constants and field helpers for decode
// Revision   : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

  typedef enum logic [0:0] {
    S_DECODE = 1'b0,
    S_IMM    = 1'b1
  } state_e;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_LDD = 5'b10000;
  localparam logic [4:0] OP_LDM = 5'b11000;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam int RDST_MSB = 10;
  localparam int RDST_LSB = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 5;
  localparam int RS2_MSB  = 4;
  localparam int RS2_LSB  = 2;

  function automatic logic is_two_word(input logic [4:0] op);
    return (op[4:3] == 2'b11);
  endfunction

  function automatic logic is_mem_read(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect : load-use compare of the EX destination against ID sources
// Revision      : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import decode_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [2:0] ex_rdst_i,
  input  logic [4:0] opcode_i,
  input  logic [2:0] rsrc1_i,
  input  logic [2:0] rsrc2_i,
  output logic       hazard_o
);

  // A NOP never consumes registers, so it can never wait on a load.
  assign hazard_o = ex_mem_read_i && (opcode_i != OP_NOP) &&
                    ((ex_rdst_i == rsrc1_i) || (ex_rdst_i == rsrc2_i));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : decodes fetch words into ID/EX, handles stalls/flushes/imm
// Revision     : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction_r,
  input  logic [PC_W-1:0]    pc_plus_one_r,
  input  logic               ex_mem_read,
  input  logic [2:0]         ex_rdst,
  input  logic               branch_taken,
  output logic               pc_write,
  output logic               clear_instruction,
  output logic               id_ex_valid,
  output logic [4:0]         id_ex_opcode,
  output logic [2:0]         id_ex_rdst,
  output logic [2:0]         id_ex_rsrc1,
  output logic [2:0]         id_ex_rsrc2,
  output logic [INSTR_W-1:0] id_ex_imm,
  output logic [PC_W-1:0]    id_ex_pc_plus_one,
  output logic [CNT_W-1:0]   stall_count
);

  state_e             state_q;
  logic               valid_q;
  logic [4:0]         opcode_q;
  logic [2:0]         rdst_q, rsrc1_q, rsrc2_q;
  logic [INSTR_W-1:0] imm_q;
  logic [PC_W-1:0]    pc_q;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic [4:0]         hdr_opcode_q;
  logic [2:0]         hdr_rdst_q, hdr_rsrc1_q, hdr_rsrc2_q;
  logic [PC_W-1:0]    hdr_pc_q;

  logic [4:0]         w_opcode;
  logic [2:0]         w_rdst, w_rsrc1, w_rsrc2;
  logic               w_hazard;
  logic               w_stall;
  logic [1:0]         w_unused_bits;

  assign w_opcode      = instruction_r[OPC_MSB:OPC_LSB];
  assign w_rdst        = instruction_r[RDST_MSB:RDST_LSB];
  assign w_rsrc1       = instruction_r[RS1_MSB:RS1_LSB];
  assign w_rsrc2       = instruction_r[RS2_MSB:RS2_LSB];
  assign w_unused_bits = instruction_r[1:0];

  hazard_detect u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rdst_i     (ex_rdst),
    .opcode_i      (w_opcode),
    .rsrc1_i       (w_rsrc1),
    .rsrc2_i       (w_rsrc2),
    .hazard_o      (w_hazard)
  );

  // The word in S_IMM is raw immediate data, so it is never hazard-checked.
  assign w_stall           = !reset && !branch_taken && (state_q == S_DECODE) && w_hazard;
  assign pc_write          = !w_stall;
  assign clear_instruction = !reset && branch_taken;
  assign stall_count_d     = (stall_count_q == {CNT_W{1'b1}}) ? stall_count_q
                                                              : stall_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      state_q      <= S_DECODE;
      valid_q      <= 1'b0;
      opcode_q     <= '0;
      rdst_q       <= '0;
      rsrc1_q      <= '0;
      rsrc2_q      <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      hdr_opcode_q <= '0;
      hdr_rdst_q   <= '0;
      hdr_rsrc1_q  <= '0;
      hdr_rsrc2_q  <= '0;
      hdr_pc_q     <= '0;
      if (reset) stall_count_q <= '0;
    end else begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      rdst_q   <= '0;
      rsrc1_q  <= '0;
      rsrc2_q  <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      case (state_q)
        S_IMM: begin
          valid_q  <= 1'b1;
          opcode_q <= hdr_opcode_q;
          rdst_q   <= hdr_rdst_q;
          rsrc1_q  <= hdr_rsrc1_q;
          rsrc2_q  <= hdr_rsrc2_q;
          imm_q    <= instruction_r;
          pc_q     <= hdr_pc_q;
          state_q  <= S_DECODE;
        end
        default: begin
          if (w_hazard) begin
            stall_count_q <= stall_count_d;
          end else if (w_opcode == OP_NOP) begin
            state_q <= S_DECODE;
          end else if (is_two_word(w_opcode)) begin
            hdr_opcode_q <= w_opcode;
            hdr_rdst_q   <= w_rdst;
            hdr_rsrc1_q  <= w_rsrc1;
            hdr_rsrc2_q  <= w_rsrc2;
            hdr_pc_q     <= pc_plus_one_r;
            state_q      <= S_IMM;
          end else begin
            valid_q  <= 1'b1;
            opcode_q <= w_opcode;
            rdst_q   <= w_rdst;
            rsrc1_q  <= w_rsrc1;
            rsrc2_q  <= w_rsrc2;
            pc_q     <= pc_plus_one_r;
          end
        end
      endcase
    end
  end

  assign id_ex_valid       = valid_q;
  assign id_ex_opcode      = opcode_q;
  assign id_ex_rdst        = rdst_q;
  assign id_ex_rsrc1       = rsrc1_q;
  assign id_ex_rsrc2       = rsrc2_q;
  assign id_ex_imm         = imm_q;
  assign id_ex_pc_plus_one = pc_q;
  assign stall_count       = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage : directed plus randomized bench with a behavioural model
// Revision        : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction_r;
  logic [31:0] pc_plus_one_r;
  logic        ex_mem_read;
  logic [2:0]  ex_rdst;
  logic        branch_taken;
  logic        pc_write, clear_instruction, id_ex_valid;
  logic [4:0]  id_ex_opcode;
  logic [2:0]  id_ex_rdst, id_ex_rsrc1, id_ex_rsrc2;
  logic [15:0] id_ex_imm;
  logic [31:0] id_ex_pc_plus_one;
  logic [15:0] stall_count;

  int cmp_count = 0;
  int err_count = 0;

  // Reference model: what ID/EX should hold and whether an immediate is owed.
  logic        m_valid;
  logic [4:0]  m_op;
  logic [2:0]  m_rd, m_r1, m_r2;
  logic [15:0] m_imm;
  logic [31:0] m_pc;
  int          m_stalls;
  bit          m_owe_imm;
  logic [15:0] m_hdr_word;
  logic [31:0] m_hdr_pc;
  logic        m_pcw, m_clr;
  logic        obs_pcw, obs_clr;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .INSTR_W(16), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .instruction_r     (instruction_r),
    .pc_plus_one_r     (pc_plus_one_r),
    .ex_mem_read       (ex_mem_read),
    .ex_rdst           (ex_rdst),
    .branch_taken      (branch_taken),
    .pc_write          (pc_write),
    .clear_instruction (clear_instruction),
    .id_ex_valid       (id_ex_valid),
    .id_ex_opcode      (id_ex_opcode),
    .id_ex_rdst        (id_ex_rdst),
    .id_ex_rsrc1       (id_ex_rsrc1),
    .id_ex_rsrc2       (id_ex_rsrc2),
    .id_ex_imm         (id_ex_imm),
    .id_ex_pc_plus_one (id_ex_pc_plus_one),
    .stall_count       (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    assert (got === exp) else begin
      err_count++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_bubble();
    m_valid = 0; m_op = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0;
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] imm, input logic [31:0] pc);
    m_valid = 1; m_op = w[15:11]; m_rd = w[10:8]; m_r1 = w[7:5]; m_r2 = w[4:2];
    m_imm = imm; m_pc = pc;
  endtask

  // One clock: apply inputs, check fetch controls, advance model, check ID/EX.
  task automatic cyc(input bit rst, input logic [15:0] ins, input logic [31:0] pc,
                     input bit mr, input logic [2:0] erd, input bit br);
    logic [4:0] op;
    bit haz;
    reset = rst; instruction_r = ins; pc_plus_one_r = pc;
    ex_mem_read = mr; ex_rdst = erd; branch_taken = br;
    op  = ins[15:11];
    haz = mr && (op != 5'd0) && (erd == ins[7:5] || erd == ins[4:2]);
    m_pcw = 1; m_clr = 0;
    if (rst) begin
      set_bubble(); m_stalls = 0; m_owe_imm = 0;
    end else if (br) begin
      m_clr = 1; set_bubble(); m_owe_imm = 0;
    end else if (m_owe_imm) begin
      issue(m_hdr_word, ins, m_hdr_pc); m_owe_imm = 0;
    end else if (haz) begin
      m_pcw = 0; set_bubble();
      if (m_stalls < 65535) m_stalls++;
    end else if (op == 5'd0) begin
      set_bubble();
    end else if (op[4:3] == 2'b11) begin
      set_bubble(); m_owe_imm = 1; m_hdr_word = ins; m_hdr_pc = pc;
    end else begin
      issue(ins, 16'h0, pc);
    end
    #1;
    obs_pcw = pc_write; obs_clr = clear_instruction;
    chk("pc_write", {31'd0, pc_write}, {31'd0, m_pcw});
    chk("clear_instruction", {31'd0, clear_instruction}, {31'd0, m_clr});
    @(posedge clk); #1;
    chk("id_ex_valid", {31'd0, id_ex_valid}, {31'd0, m_valid});
    chk("id_ex_opcode", {27'd0, id_ex_opcode}, {27'd0, m_op});
    chk("id_ex_rdst", {29'd0, id_ex_rdst}, {29'd0, m_rd});
    chk("id_ex_rsrc1", {29'd0, id_ex_rsrc1}, {29'd0, m_r1});
    chk("id_ex_rsrc2", {29'd0, id_ex_rsrc2}, {29'd0, m_r2});
    chk("id_ex_imm", {16'd0, id_ex_imm}, {16'd0, m_imm});
    chk("id_ex_pc_plus_one", id_ex_pc_plus_one, m_pc);
    chk("stall_count", {16'd0, stall_count}, m_stalls);
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  op;
    int          pick;
    m_stalls = 0; m_owe_imm = 0; m_hdr_word = 0; m_hdr_pc = 0;
    set_bubble();
    reset = 1; instruction_r = 16'h294C; pc_plus_one_r = 32'h21;
    ex_mem_read = 0; ex_rdst = 0; branch_taken = 0;
    @(posedge clk); #1;

    // Reset held two cycles
    cyc(1, 16'h294C, 32'h21, 0, 3'd0, 0);
    cyc(1, 16'h294C, 32'h21, 0, 3'd0, 0);
    chk("reset_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("reset_stall", {16'd0, stall_count}, 32'd0);
    chk("reset_pcw", {31'd0, obs_pcw}, 32'd1);
    chk("reset_clr", {31'd0, obs_clr}, 32'd0);

    // ADD R1,R2,R3
    cyc(0, 16'h294C, 32'h21, 0, 3'd0, 0);
    chk("add_opcode", {27'd0, id_ex_opcode}, 32'h05);
    chk("add_fields", {20'd0, id_ex_rdst, id_ex_rsrc1, id_ex_rsrc2, 3'd0},
        {20'd0, 3'd1, 3'd2, 3'd3, 3'd0});
    chk("add_pc", id_ex_pc_plus_one, 32'h21);

    // LDM R4 with immediate 1234
    cyc(0, 16'hC400, 32'h30, 0, 3'd0, 0);
    chk("ldm_hdr_bubble", {31'd0, id_ex_valid}, 32'd0);
    cyc(0, 16'h1234, 32'h31, 0, 3'd0, 0);
    chk("ldm_imm", {16'd0, id_ex_imm}, 32'h1234);
    chk("ldm_opcode", {27'd0, id_ex_opcode}, 32'h18);
    chk("ldm_pc", id_ex_pc_plus_one, 32'h30);

    // Load-use stall, then release
    cyc(0, 16'h2D60, 32'h40, 1, 3'd3, 0);
    chk("stall_pcw", {31'd0, obs_pcw}, 32'd0);
    chk("stall_cnt1", {16'd0, stall_count}, 32'd1);
    cyc(0, 16'h2D60, 32'h40, 0, 3'd3, 0);
    chk("release_rdst", {29'd0, id_ex_rdst}, 32'd5);
    chk("release_valid", {31'd0, id_ex_valid}, 32'd1);

    // Branch flush during S_IMM
    cyc(0, 16'hC400, 32'h50, 0, 3'd0, 0);
    cyc(0, 16'h1234, 32'h51, 0, 3'd0, 1);
    chk("flush_clr", {31'd0, obs_clr}, 32'd1);
    chk("flush_bubble", {31'd0, id_ex_valid}, 32'd0);
    cyc(0, 16'h294C, 32'h52, 0, 3'd0, 0);
    chk("post_flush_add", {27'd0, id_ex_opcode}, 32'h05);
    chk("post_flush_imm", {16'd0, id_ex_imm}, 32'h0);

    // Branch beats hazard
    cyc(0, 16'h2D60, 32'h60, 1, 3'd3, 1);
    chk("br_haz_pcw", {31'd0, obs_pcw}, 32'd1);
    chk("br_haz_clr", {31'd0, obs_clr}, 32'd1);
    chk("br_haz_stall", {16'd0, stall_count}, 32'd1);

    // Reset in S_IMM discards pending header
    cyc(0, 16'hC400, 32'h70, 0, 3'd0, 0);
    cyc(1, 16'h1234, 32'h71, 0, 3'd0, 0);
    cyc(0, 16'h294C, 32'h72, 0, 3'd0, 0);
    chk("rst_imm_add", {27'd0, id_ex_opcode}, 32'h05);

    // Randomized run; a stalled word is re-presented unchanged
    w = 16'h294C;
    for (int i = 0; i < 400; i++) begin
      if (obs_pcw) begin
        pick = $urandom_range(0, 4);
        case (pick)
          0: op = 5'b00000;
          1: op = 5'b00101;
          2: op = 5'b10000;
          3: op = 5'b11000;
          default: op = 5'($urandom);
        endcase
        w = {op, 11'($urandom)};
      end
      cyc(($urandom_range(0, 49) == 0), w, $urandom,
          ($urandom_range(0, 9) < 4), 3'($urandom), ($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch→decode interface.
- Takes the registered fetch outputs (instruction word, PC+1) and decodes them into the ID/EX pipeline register.
- Drives the fetch control lines back to fetch: pc_write (stall) and clear_instruction (flush).
- Handles two-word instructions with an immediate-capture FSM, load-use stalls, and branch flushes.

Parameters:
- PC_W, 32, width of pc_plus_one passthrough.
- INSTR_W, 16, instruction/immediate word width.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction_r  in  16  instruction word from fetch register.
- pc_plus_one_r  in  32  PC+1 from fetch register.
- ex_mem_read  in  1  instruction currently in EX reads memory.
- ex_rdst  in  3  destination register of instruction in EX.
- branch_taken  in  1  EX resolved a taken branch (flush request).
- pc_write  out  1  combinational; 0 = fetch holds PC and re-presents the same instruction_r/pc_plus_one_r next cycle.
- clear_instruction  out  1  combinational; 1 = fetch replaces its next instruction with NOP.
- id_ex_valid  out  1  registered; ID/EX holds a real instruction.
- id_ex_opcode  out  5  registered opcode.
- id_ex_rdst, id_ex_rsrc1, id_ex_rsrc2  out  3 each  registered register fields.
- id_ex_imm  out  16  registered immediate (0 for one-word instructions).
- id_ex_pc_plus_one  out  32  registered PC+1 of the header word.
- stall_count  out  16  saturating count of load-use stall cycles.

Behaviour:
- Field split: opcode [15:11], rdst [10:8], rsrc1 [7:5], rsrc2 [4:2], [1:0] ignored.
- Two-word instruction: opcode[4:3]==2'b11.
- Memory-read instruction: opcode[4:3]==2'b10.
- NOP: opcode 5'b00000.
- Reset (synchronous): state=S_DECODE, all id_ex_* = 0, id_ex_valid=0, stall_count=0, pending header cleared.
- While reset is high: pc_write=1, clear_instruction=0.
- Bubble: id_ex_valid=0, all other id_ex_* = 0.
- Latency: one-word instruction appears on id_ex_* one cycle after it is on instruction_r. Two-word instruction appears one cycle after its immediate word.
- FSM states: S_DECODE, S_IMM.
- Priority each cycle: reset > branch_taken > load-use hazard > normal.
- branch_taken=1 (any state):
  - clear_instruction=1, pc_write=1.
  - ID/EX ← bubble; state→S_DECODE; pending header discarded.
- S_DECODE, hazard, defined as ex_mem_read=1 AND opcode≠NOP AND (ex_rdst==rsrc1 OR ex_rdst==rsrc2):
  - pc_write=0; ID/EX ← bubble; stall_count+1 (saturating at 2^CNT_W-1); state unchanged.
  - Same word is re-evaluated next cycle.
- S_DECODE, NOP: ID/EX ← bubble.
- S_DECODE, one-word, no hazard: ID/EX ← decoded fields, imm=0, valid=1.
- S_DECODE, two-word, no hazard:
  - Latch opcode/rdst/rsrc1/rsrc2/pc_plus_one_r into pending header.
  - ID/EX ← bubble; state→S_IMM; pc_write=1.
- S_IMM:
  - instruction_r is raw immediate: never decoded, never hazard-checked.
  - ID/EX ← pending header + imm=instruction_r, valid=1; state→S_DECODE.
- Hazard check for a two-word instruction occurs only on its header cycle.
- Back-to-back stalls allowed indefinitely; ex_mem_read dropping releases the stall on the same cycle's decision.
- Reset asserted mid S_IMM: pending discarded, state→S_DECODE, no partial issue.

Decomposition:
- Package decode_pkg holds:
  - state enum {S_DECODE, S_IMM}
  - opcode constants OP_NOP=5'b00000, OP_ADD=5'b00101, OP_LDD=5'b10000, OP_LDM=5'b11000
  - field bit-position localparams
  - functions is_two_word(), is_mem_read()
- One sub-module: hazard_detect (combinational compare of ex_mem_read/ex_rdst against rsrc1/rsrc2, with NOP qualifier).
- FSM, pending header register, and ID/EX register live in decode_stage.

Test Plan:
- Reset held 2 cycles with instruction_r=16'h294C -> id_ex_valid=0, all id_ex_*=0, stall_count=0, pc_write=1, clear_instruction=0.
- ADD R1,R2,R3 (16'h294C), pc_plus_one_r=32'h21 -> next cycle: valid=1, opcode=5'b00101, rdst=1, rsrc1=2, rsrc2=3, imm=0, pc_plus_one=32'h21.
- LDM R4 (16'hC400, pc+1=32'h30), then 16'h1234 -> cycle1 bubble; cycle2: valid=1, opcode=5'b11000, rdst=4, imm=16'h1234, pc_plus_one=32'h30.
- ex_mem_read=1, ex_rdst=3, instruction 16'h2D60 (rsrc1=3) -> pc_write=0, bubble, stall_count=1. Drop ex_mem_read next cycle -> issues with rdst=5.
- LDM header accepted; branch_taken=1 during S_IMM -> clear_instruction=1, bubble, state S_DECODE. Next 16'h294C decodes as ADD, not as immediate.
- branch_taken=1 together with the hazard condition -> pc_write=1, clear_instruction=1, stall_count unchanged.
